// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if
//   Groups the two requester command/response channels, the single RAM port
//   and the busy flag shared between the arbiter and its surroundings.
//   Parameters: AW (RAM address width), DW (RAM data width).
//   Modports:
//     slave  - arbiter side: takes commands and ram_dout, drives ready,
//              responses, RAM controls and busy.
//     master - requester/RAM side: the mirror image.
interface ram_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic          req0_we,    req1_we;
  logic [AW-1:0] req0_addr,  req1_addr;
  logic [DW-1:0] req0_din,   req1_din;
  logic          rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp0_dout,  rsp1_dout;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          busy;

  modport slave (
    input  req0_valid, req1_valid, req0_we, req1_we,
    input  req0_addr, req1_addr, req0_din, req1_din, ram_dout,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp0_dout, rsp1_dout, ram_we, ram_addr, ram_din, busy
  );

  modport master (
    output req0_valid, req1_valid, req0_we, req1_we,
    output req0_addr, req1_addr, req0_din, req1_din, ram_dout,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp0_dout, rsp1_dout, ram_we, ram_addr, ram_din, busy
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one RAM port (registered read address, unregistered data out)
//   between two requesters with round-robin arbitration. One command is
//   accepted per cycle; a read answers on rspN one cycle after acceptance.
//   Optional feature: define RAM_PORT_ARBITER_INIT_CLEAR_EN to clear every
//   RAM address to 0 after reset (busy = 1 meanwhile) before serving commands.
// Ports:
//   clk   - single clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - ram_port_arbiter_if.slave: requester channels, RAM port, busy
module ram_port_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_port_arbiter_if.slave bus
);
  logic          inRun;
  logic          ptrReg, ptrNext;
  logic [1:0]    reqValid, reqWe, grant;
  logic [AW-1:0] reqAddr [2];
  logic [DW-1:0] reqDin  [2];
  logic          accept, grantIdx;
  logic          rspPendReg [2];
  logic [DW-1:0] rspHoldReg [2];
  logic [DW-1:0] rspDout    [2];
  logic          ramWe;
  logic [AW-1:0] ramAddr;
  logic [DW-1:0] ramDin;

  assign reqValid   = {bus.req1_valid, bus.req0_valid};
  assign reqWe      = {bus.req1_we, bus.req0_we};
  assign reqAddr[0] = bus.req0_addr;
  assign reqAddr[1] = bus.req1_addr;
  assign reqDin[0]  = bus.req0_din;
  assign reqDin[1]  = bus.req1_din;

`ifdef RAM_PORT_ARBITER_INIT_CLEAR_EN
  typedef enum logic {INIT, RUN} state_t;
  state_t        stateReg, stateNext;
  logic [AW-1:0] clrCntReg, clrCntNext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg  <= INIT;
      clrCntReg <= '0;
    end else begin
      stateReg  <= stateNext;
      clrCntReg <= clrCntNext;
    end
  end

  // The clear counter walks every address once; leaving INIT after the
  // all-ones address has been written.
  always_comb begin
    stateNext  = stateReg;
    clrCntNext = clrCntReg;
    case (stateReg)
      INIT: begin
        clrCntNext = clrCntReg + 1'b1;
        if (clrCntReg == '1) stateNext = RUN;
      end
      RUN: begin
      end
    endcase
  end

  assign inRun    = (stateReg == RUN);
  // Reset is folded in so busy reads 0 while rst_n is held low.
  assign bus.busy = rst_n & (stateReg == INIT);
`else
  assign inRun    = 1'b1;
  assign bus.busy = 1'b0;
`endif

  // Grant: favoured requester first, otherwise the other one. rst_n gates
  // the grant so nothing is accepted or driven while reset is held.
  always_comb begin
    grant = '0;
    if (rst_n && inRun) begin
      if (reqValid[ptrReg])       grant[ptrReg]  = 1'b1;
      else if (reqValid[~ptrReg]) grant[~ptrReg] = 1'b1;
    end
  end

  assign accept   = |grant;
  assign grantIdx = grant[1];
  // After an acceptance the loser becomes favoured; otherwise hold.
  assign ptrNext  = accept ? ~grantIdx : ptrReg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptrReg <= 1'b0;
    else        ptrReg <= ptrNext;
  end

  always_comb begin
    ramWe   = 1'b0;
    ramAddr = '0;
    ramDin  = '0;
    if (accept) begin
      ramWe   = reqWe[grantIdx];
      ramAddr = reqAddr[grantIdx];
      ramDin  = reqDin[grantIdx];
    end
`ifdef RAM_PORT_ARBITER_INIT_CLEAR_EN
    else if (rst_n && !inRun) begin
      ramWe   = 1'b1;
      ramAddr = clrCntReg;
    end
`endif
  end

  // Per-requester response path: the RAM returns data the cycle after the
  // address was presented, so the response is ram_dout passed through while
  // pending, and a held copy otherwise.
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : gRsp
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rspPendReg[gi] <= 1'b0;
        rspHoldReg[gi] <= '0;
      end else begin
        rspPendReg[gi] <= grant[gi] & ~reqWe[gi];
        if (rspPendReg[gi]) rspHoldReg[gi] <= bus.ram_dout;
      end
    end
    assign rspDout[gi] = rspPendReg[gi] ? bus.ram_dout : rspHoldReg[gi];
  end

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];
  assign bus.rsp0_valid = rspPendReg[0];
  assign bus.rsp1_valid = rspPendReg[1];
  assign bus.rsp0_dout  = rspDout[0];
  assign bus.rsp1_dout  = rspDout[1];
  assign bus.ram_we     = ramWe;
  assign bus.ram_addr   = ramAddr;
  assign bus.ram_din    = ramDin;
endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.AW(AW), .DW(DW)) bus();
  ram_port_arbiter #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // RAM: address registered on the clock, data output read combinationally.
  bit [DW-1:0] mem [DEPTH];
  bit [AW-1:0] ramAddrQ;
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    ramAddrQ <= bus.ram_addr;
  end
  assign bus.ram_dout = mem[ramAddrQ];

  // Reference model state
  int total = 0;
  int bad = 0;
  int fav = 0;
  int initCnt = 0;
  bit expPend [2];
  bit [7:0] expRsp [2];
  bit [7:0] expHold [2];
  bit [7:0] shadow [DEPTH];
  bit lastAcc [2];

  task automatic cmp(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_cycle();
    bit v [2];
    bit w [2];
    bit [7:0] a [2];
    bit [7:0] d [2];
    bit rv [2];
    bit [7:0] rd [2];
    bit newPend [2];
    bit expWe;
    int g;
    v[0] = bus.req0_valid; v[1] = bus.req1_valid;
    w[0] = bus.req0_we;    w[1] = bus.req1_we;
    a[0] = bus.req0_addr;  a[1] = bus.req1_addr;
    d[0] = bus.req0_din;   d[1] = bus.req1_din;
    rv[0] = bus.rsp0_valid; rv[1] = bus.rsp1_valid;
    rd[0] = bus.rsp0_dout;  rd[1] = bus.rsp1_dout;
    lastAcc[0] = 1'b0; lastAcc[1] = 1'b0;
    if (!rst_n) begin
      cmp("rst ready0", bus.req0_ready, 0);
      cmp("rst ready1", bus.req1_ready, 0);
      cmp("rst rsp0_valid", bus.rsp0_valid, 0);
      cmp("rst rsp1_valid", bus.rsp1_valid, 0);
      cmp("rst rsp0_dout", bus.rsp0_dout, 0);
      cmp("rst rsp1_dout", bus.rsp1_dout, 0);
      cmp("rst ram_we", bus.ram_we, 0);
      cmp("rst ram_addr", bus.ram_addr, 0);
      cmp("rst ram_din", bus.ram_din, 0);
      cmp("rst busy", bus.busy, 0);
      fav = 0; initCnt = 0;
      for (int i = 0; i < 2; i++) begin
        expPend[i] = 1'b0; expHold[i] = 8'h00;
      end
      return;
    end
    for (int i = 0; i < 2; i++) begin
      cmp($sformatf("rsp%0d_valid", i), rv[i], expPend[i]);
      if (expPend[i]) expHold[i] = expRsp[i];
      cmp($sformatf("rsp%0d_dout", i), rd[i], expHold[i]);
      newPend[i] = 1'b0;
    end
`ifdef RAM_PORT_ARBITER_INIT_CLEAR_EN
    if (initCnt < DEPTH) begin
      cmp("init busy", bus.busy, 1);
      cmp("init ready0", bus.req0_ready, 0);
      cmp("init ready1", bus.req1_ready, 0);
      cmp("init ram_we", bus.ram_we, 1);
      cmp("init ram_addr", bus.ram_addr, initCnt);
      cmp("init ram_din", bus.ram_din, 0);
      shadow[initCnt] = 8'h00;
      initCnt++;
      expPend = newPend;
      return;
    end
`endif
    cmp("run busy", bus.busy, 0);
    g = -1;
    if (v[fav]) g = fav;
    else if (v[1-fav]) g = 1 - fav;
    cmp("ready0", bus.req0_ready, (g == 0));
    cmp("ready1", bus.req1_ready, (g == 1));
    expWe = 1'b0;
    if (g >= 0) expWe = w[g];
    cmp("ram_we", bus.ram_we, expWe);
    if (g >= 0) begin
      cmp("ram_addr", bus.ram_addr, a[g]);
      if (w[g]) begin
        cmp("ram_din", bus.ram_din, d[g]);
        shadow[a[g]] = d[g];
      end else begin
        newPend[g] = 1'b1;
        expRsp[g] = shadow[a[g]];
      end
      lastAcc[g] = 1'b1;
      fav = 1 - g;
    end
    expPend = newPend;
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic run1();
    tick();
    adv();
  endtask

  task automatic set_req(int i, bit v, bit we, bit [7:0] a, bit [7:0] d);
    if (i == 0) begin
      bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a; bus.req0_din = d;
    end else begin
      bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a; bus.req1_din = d;
    end
  endtask

  task automatic idle();
    set_req(0, 0, 0, 8'h00, 8'h00);
    set_req(1, 0, 0, 8'h00, 8'h00);
  endtask

  task automatic finish_init();
    int k;
    k = 0;
    while (initCnt < DEPTH && k < 400) begin
      run1();
      k++;
    end
    if (initCnt < DEPTH) cmp("init timeout", initCnt, DEPTH);
  endtask

  int cnt0, cnt1, busyCnt;

  initial begin
    idle();
    rst_n = 1'b0;
    // Valid high during reset: ready must still be 0.
    set_req(0, 1, 0, 8'h01, 8'h00);
    set_req(1, 1, 0, 8'h02, 8'h00);
    adv();
    run1();
    tick();
    cmp("reset ready0 lit", bus.req0_ready, 0);
    adv();
    idle();
    rst_n = 1'b1;

`ifdef RAM_PORT_ARBITER_INIT_CLEAR_EN
    repeat (64) run1();
    rst_n = 1'b0;
    tick();
    cmp("midinit rst ram_we lit", bus.ram_we, 0);
    adv();
    rst_n = 1'b1;
    tick();
    cmp("restart addr lit", bus.ram_addr, 8'h00);
    busyCnt = bus.busy ? 1 : 0;
    adv();
    for (int k = 0; k < 400 && initCnt < DEPTH; k++) begin
      tick();
      if (bus.busy) busyCnt++;
      adv();
    end
    cmp("busy length lit", busyCnt, 256);
    set_req(0, 1, 0, 8'h7F, 8'h00);
    run1();
    idle();
    tick();
    cmp("init read 7F valid lit", bus.rsp0_valid, 1);
    cmp("init read 7F data lit", bus.rsp0_dout, 8'h00);
    adv();
`endif

    // Requester 0 write then immediate read of the same address.
    set_req(0, 1, 1, 8'h10, 8'hA5);
    tick();
    cmp("wr10 ready0 lit", bus.req0_ready, 1);
    adv();
    set_req(0, 1, 0, 8'h10, 8'h00);
    run1();
    idle();
    tick();
    cmp("rd10 valid lit", bus.rsp0_valid, 1);
    cmp("rd10 data lit", bus.rsp0_dout, 8'hA5);
    adv();

    // Requester 1 alone reads 0x20 holding 0x5A.
    set_req(1, 1, 1, 8'h20, 8'h5A);
    run1();
    set_req(1, 1, 0, 8'h20, 8'h00);
    tick();
    cmp("rd20 ready1 lit", bus.req1_ready, 1);
    cmp("rd20 ready0 lit", bus.req0_ready, 0);
    adv();
    idle();
    tick();
    cmp("rd20 rsp1 valid lit", bus.rsp1_valid, 1);
    cmp("rd20 rsp1 data lit", bus.rsp1_dout, 8'h5A);
    cmp("rd20 rsp0 valid lit", bus.rsp0_valid, 0);
    adv();

    // Both requesters continuously valid for 8 cycles.
    cnt0 = 0; cnt1 = 0;
    set_req(0, 1, 1, 8'h30, 8'h11);
    set_req(1, 1, 1, 8'h31, 8'h22);
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.req0_ready) cnt0++;
      if (bus.req1_ready) cnt1++;
      adv();
    end
    cmp("rr grants0 lit", cnt0, 4);
    cmp("rr grants1 lit", cnt1, 4);
    idle();

    // Pre-reset write, then a read abandoned by reset.
    set_req(0, 1, 1, 8'h33, 8'h77);
    run1();
    set_req(0, 1, 0, 8'h10, 8'h00);
    run1();
    idle();
    rst_n = 1'b0;
    tick();
    cmp("abandon rsp0 lit", bus.rsp0_valid, 0);
    adv();
    rst_n = 1'b1;
`ifdef RAM_PORT_ARBITER_INIT_CLEAR_EN
    finish_init();
`else
    set_req(0, 1, 0, 8'h33, 8'h00);
    tick();
    cmp("first cycle ready0 lit", bus.req0_ready, 1);
    cmp("first cycle busy lit", bus.busy, 0);
    adv();
    idle();
    tick();
    cmp("rd33 valid lit", bus.rsp0_valid, 1);
    cmp("rd33 data lit", bus.rsp0_dout, 8'h77);
    adv();
`endif

    // Randomized traffic; a pending command is held until accepted.
    for (int n = 0; n < 500; n++) begin
      if (!(bus.req0_valid && !lastAcc[0]))
        set_req(0, ($urandom_range(0, 99) < 65), 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 15)), 8'($urandom));
      if (!(bus.req1_valid && !lastAcc[1]))
        set_req(1, ($urandom_range(0, 99) < 65), 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 15)), 8'($urandom));
      run1();
    end
    idle();
    run1();
    run1();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
